// File: rtl/ns_quantizer_pkg.sv
// Shared types and width helpers for the noise-shaping quantizer.
package ns_quantizer_pkg;

    // Noise-shaping mode as presented on mode_i.
    typedef enum logic [1:0] {
        MODE_PLAIN = 2'b00,
        MODE_EF1   = 2'b01,
        MODE_EF2   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Guard bits above the sample width: enough headroom for x + 2*e1 - e2
    // plus the half-step rounding offset without wrapping.
    localparam int ACC_GUARD = 3;

    // Internal accumulator width derived from the input sample width.
    function automatic int acc_width(input int in_w);
        return in_w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/ns_quant_core.sv
// Combinational round / clamp / error path of the noise-shaping quantizer.
// Takes the shaped value v and produces the clamped level, the residual
// error saturated to the sample width, and the overload flag.
module ns_quant_core
    import ns_quantizer_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 3,
    parameter int ACC_W = acc_width(IN_W)
) (
    input  logic signed [ACC_W-1:0] v,
    output logic signed [OUT_W-1:0] q_clamped,
    output logic signed [IN_W-1:0]  e,
    output logic                    ovl
);

    localparam int SH = IN_W - OUT_W;

    localparam logic signed [ACC_W-1:0] HALF_STEP = ACC_W'(2 ** (SH - 1));
    localparam logic signed [ACC_W-1:0] Q_MAX     = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN     = -ACC_W'(2 ** (OUT_W - 1));
    localparam logic signed [ACC_W-1:0] E_MAX     = ACC_W'(2 ** (IN_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] E_MIN     = -ACC_W'(2 ** (IN_W - 1));

    // Limit the rounded level to the range representable by the output code.
    function automatic logic signed [ACC_W-1:0] clamp_q(input logic signed [ACC_W-1:0] q);
        if (q > Q_MAX) begin
            return Q_MAX;
        end
        if (q < Q_MIN) begin
            return Q_MIN;
        end
        return q;
    endfunction

    // Saturate a wide error term to the signed sample range.
    function automatic logic signed [IN_W-1:0] sat_e(input logic signed [ACC_W-1:0] x);
        if (x > E_MAX) begin
            return E_MAX[IN_W-1:0];
        end
        if (x < E_MIN) begin
            return E_MIN[IN_W-1:0];
        end
        return x[IN_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] q_floor;
    logic signed [ACC_W-1:0] q_wide;
    logic signed [ACC_W-1:0] e_wide;

    // Round half-up by adding half a step then flooring with an arithmetic
    // shift; the error is measured against the clamped level so overloads
    // show up as a large residual.
    always_comb begin
        rounded = v + HALF_STEP;
        q_floor = rounded >>> SH;
        q_wide  = clamp_q(q_floor);
        e_wide  = v - (q_wide <<< SH);
    end

    assign q_clamped = q_wide[OUT_W-1:0];
    assign e         = sat_e(e_wide);
    assign ovl       = (q_wide != q_floor);

endmodule

// File: rtl/ns_quantizer.sv
// Noise-shaping requantizer: reduces a signed IN_W sample to an OUT_W
// offset-binary code, feeding back past quantization errors (none, first
// order or second order) so the error spectrum is pushed to high frequency.
// One-deep output register with valid/ready handshake.
module ns_quantizer
    import ns_quantizer_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic [1:0]              mode_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [IN_W-1:0]  x_in_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUT_W-1:0]        code_o,
    output logic signed [IN_W-1:0]  err_o,
    output logic                    ovl_o,
    output logic [CNT_W-1:0]        ovl_cnt_o
);

    localparam int ACC_W = acc_width(IN_W);
    localparam logic [OUT_W-1:0] CODE_BIAS = OUT_W'(2 ** (OUT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // ---- stage p0: acceptance, error feedback and quantization ----
    logic                    accept_p0;
    mode_e                   mode_p0;
    logic signed [ACC_W-1:0] fb_p0;
    logic signed [ACC_W-1:0] v_p0;
    logic signed [OUT_W-1:0] qc_p0;
    logic signed [IN_W-1:0]  e_p0;
    logic                    ovl_p0;
    logic [OUT_W-1:0]        code_p0;

    // ---- stage p1: output registers and error history ----
    logic                    vld_p1;
    logic [OUT_W-1:0]        code_p1;
    logic signed [IN_W-1:0]  err_p1;
    logic                    ovl_p1;
    logic signed [IN_W-1:0]  e1_p1;
    logic signed [IN_W-1:0]  e2_p1;
    logic [CNT_W-1:0]        cnt_p1;

    assign in_ready_o = !vld_p1 || out_ready_i;
    assign accept_p0  = in_valid_i && in_ready_o;
    assign mode_p0    = mode_e'(mode_i);

    // Select the error-feedback term; a clear in the same cycle forces the
    // accepted sample to see no history.
    always_comb begin
        fb_p0 = '0;
        if (!clr_i) begin
            case (mode_p0)
                MODE_EF1: fb_p0 = ACC_W'(e1_p1);
                MODE_EF2: fb_p0 = (ACC_W'(e1_p1) <<< 1) - ACC_W'(e2_p1);
                default:  fb_p0 = '0;
            endcase
        end
    end

    assign v_p0 = ACC_W'(x_in_i) + fb_p0;

    ns_quant_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W)
    ) u_core (
        .v         (v_p0),
        .q_clamped (qc_p0),
        .e         (e_p0),
        .ovl       (ovl_p0)
    );

    assign code_p0 = $unsigned(qc_p0) + CODE_BIAS;

    // ---- stage p0 -> p1 register boundary ----

    // Output register: load on acceptance, drop valid once consumed, hold
    // while downstream stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            code_p1 <= '0;
            err_p1  <= '0;
            ovl_p1  <= 1'b0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            code_p1 <= code_p0;
            err_p1  <= e_p0;
            ovl_p1  <= ovl_p0;
        end else if (out_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    // Error history shifts only on acceptance; a clear wipes it and also
    // discards the error of a sample accepted in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e1_p1 <= '0;
            e2_p1 <= '0;
        end else if (clr_i) begin
            e1_p1 <= '0;
            e2_p1 <= '0;
        end else if (accept_p0) begin
            e2_p1 <= e1_p1;
            e1_p1 <= e_p0;
        end
    end

    // Saturating count of accepted clamped samples; a clear restarts it,
    // counting a clamped sample accepted in the clearing cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_p1 <= '0;
        end else if (clr_i) begin
            cnt_p1 <= (accept_p0 && ovl_p0) ? CNT_W'(1) : '0;
        end else if (accept_p0 && ovl_p0 && (cnt_p1 != CNT_MAX)) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign out_valid_o = vld_p1;
    assign code_o      = code_p1;
    assign err_o       = err_p1;
    assign ovl_o       = ovl_p1;
    assign ovl_cnt_o   = cnt_p1;

endmodule

// File: tb/tb_ns_quantizer.sv
// Self-checking bench for ns_quantizer (IN_W=16, OUT_W=3, small counter).
module tb_ns_quantizer;

    localparam int IN_W  = 16;
    localparam int OUT_W = 3;
    localparam int CNT_W = 4;
    localparam int STEP  = 8192;
    localparam int HALF  = 4096;
    localparam int CMAX  = 15;

    logic                   clk;
    logic                   rst_i;
    logic                   clr_i;
    logic [1:0]             mode_i;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] x_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       code_o;
    logic signed [IN_W-1:0] err_o;
    logic                   ovl_o;
    logic [CNT_W-1:0]       ovl_cnt;

    ns_quantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .mode_i      (mode_i),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_in_i      (x_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .code_o      (code_o),
        .err_o       (err_o),
        .ovl_o       (ovl_o),
        .ovl_cnt_o   (ovl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int err;
        int ovl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   me1 = 0;
    int   me2 = 0;
    int   mcnt = 0;
    bit   mvld = 1'b0;
    int   code_sum = 0;
    bit   sum_en = 1'b0;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check outputs against the
    // scoreboard head, predict the acceptance, then advance one clock.
    task automatic step(input bit iv, input int x, input int mode, input bit ordy,
                        input bit clr, input bit use_k = 1'b0, input int kcode = 0,
                        input int kerr = 0, input int kovl = 0);
        exp_t r;
        bit   rdy;
        bit   acc;
        int   f, v, t, q, qc, e;
        bit   ov;
        in_valid  = iv;
        x_in      = x[IN_W-1:0];
        mode_i    = 2'(mode);
        out_ready = ordy;
        clr_i     = clr;
        #1;
        rdy = !mvld || ordy;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, mvld);
        if (mvld) begin
            check("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
                check("code", code_o, sb[0].code);
                check("err", err_o, sb[0].err);
                check("ovl", ovl_o, sb[0].ovl);
                if (ordy) begin
                    if (sum_en) code_sum += int'(code_o);
                    void'(sb.pop_front());
                end
            end
        end
        acc = iv && rdy;
        if (acc) begin
            f = 0;
            if (!clr) begin
                if (mode == 1) f = me1;
                else if (mode == 2) f = 2 * me1 - me2;
            end
            v = x + f;
            t = v + HALF;
            q = (t >= 0) ? t / STEP : -((-t + STEP - 1) / STEP);
            qc = (q > 3) ? 3 : ((q < -4) ? -4 : q);
            ov = (qc != q);
            e = v - qc * STEP;
            if (e > 32767) e = 32767;
            if (e < -32768) e = -32768;
            r.code = qc + 4;
            r.err  = e;
            r.ovl  = int'(ov);
            if (use_k) begin
                r.code = kcode;
                r.err  = kerr;
                r.ovl  = kovl;
            end
            sb.push_back(r);
            mvld = 1'b1;
            if (clr) begin
                me1 = 0;
                me2 = 0;
                mcnt = ov ? 1 : 0;
            end else begin
                me2 = me1;
                me1 = e;
                if (ov && mcnt < CMAX) mcnt++;
            end
        end else begin
            if (ordy) mvld = 1'b0;
            if (clr) begin
                me1 = 0;
                me2 = 0;
                mcnt = 0;
            end
        end
        @(negedge clk);
        check("ovl_cnt", ovl_cnt, mcnt);
    endtask

    task automatic reset_mid();
        in_valid = 1'b0;
        clr_i    = 1'b0;
        rst_i    = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_code", code_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ovl", ovl_o, 0);
        check("rst_cnt", ovl_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        mvld = 1'b0;
        me1  = 0;
        me2  = 0;
        mcnt = 0;
    endtask

    initial begin
        logic [15:0] rx;
        rst_i     = 1'b1;
        clr_i     = 1'b0;
        mode_i    = 2'b00;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 1);
        check("init_code", code_o, 0);
        check("init_err", err_o, 0);
        check("init_cnt", ovl_cnt, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // plain mode points
        step(1, 0, 0, 1, 0, 1, 4, 0, 0);
        step(1, 12288, 0, 1, 0, 1, 6, -4096, 0);
        step(1, -32768, 0, 1, 0, 1, 0, 0, 0);
        step(1, 32767, 0, 1, 0, 1, 7, 8191, 1);
        check("cnt_first", ovl_cnt, 1);
        for (int i = 0; i < 18; i++) step(1, 32767, 0, 1, 0, 1, 7, 8191, 1);
        step(0, 0, 0, 1, 0);
        check("cnt_sat", ovl_cnt, CMAX);

        // first-order shaping of a constant input
        step(0, 0, 0, 1, 1);
        check("clr_cnt_idle", ovl_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(1, 4096, 1, 1, 0, 1, 5, -4096, 0);
            else            step(1, 4096, 1, 1, 0, 1, 4, 0, 0);
        end

        // second-order shaping: average code over 8 samples is 4.5
        step(0, 0, 0, 1, 1);
        sum_en   = 1'b1;
        code_sum = 0;
        for (int i = 0; i < 8; i++) step(1, 4096, 2, 1, 0);
        step(0, 0, 0, 1, 0);
        sum_en = 1'b0;
        check("ef2_sum8", code_sum, 36);

        // backpressure: five stalled cycles, then the sequence resumes
        step(0, 0, 0, 1, 1);
        step(1, 4096, 1, 1, 0, 1, 5, -4096, 0);
        for (int i = 0; i < 5; i++) step(1, 4096, 1, 0, 0);
        step(1, 4096, 1, 1, 0, 1, 4, 0, 0);
        step(1, 4096, 1, 1, 0, 1, 5, -4096, 0);
        // clear while holding an unconsumed result leaves it untouched
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // clear coinciding with an accepted sample
        step(1, 4096, 1, 1, 0);
        step(1, 4096, 1, 1, 0);
        step(1, 4096, 1, 1, 1, 1, 5, -4096, 0);
        check("clr_cnt_acc", ovl_cnt, 0);
        step(1, 4096, 1, 1, 0, 1, 5, -4096, 0);
        step(1, 32767, 0, 1, 0);
        step(1, 32767, 0, 1, 0);
        step(1, 32767, 0, 1, 1, 1, 7, 8191, 1);
        check("clr_cnt_ovl", ovl_cnt, 1);

        // reset in the middle of a stream
        step(1, 4096, 1, 1, 0);
        step(1, 4096, 1, 0, 0);
        reset_mid();
        step(1, 4096, 1, 1, 0, 1, 5, -4096, 0);
        step(0, 0, 0, 1, 0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            rx = 16'($urandom);
            step(($urandom_range(0, 3) != 0), int'($signed(rx)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ns_quantizer.md
NS_QUANTIZER -- requirements
Module: ns_quantizer

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning signed two's-complement input sample width.
REQ-002 SHALL have parameter OUT_W, default 3, meaning quantizer code width (2^OUT_W levels).
REQ-003 SHALL have parameter CNT_W, default 16, meaning overload counter width.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 clr_i  input  1  synchronous clear of error state and overload counter.
REQ-007 mode_i  input  2  noise-shaping mode: 00 plain, 01 first-order, 10 second-order, 11 reserved.
REQ-008 in_valid_i  input  1  input sample valid.
REQ-009 in_ready_o  output  1  block can accept a sample this cycle.
REQ-010 x_in_i  input  IN_W  signed input sample.
REQ-011 out_valid_o  output  1  output registers hold a valid result.
REQ-012 out_ready_i  input  1  downstream accepts the result.
REQ-013 code_o  output  OUT_W  offset-binary quantizer code.
REQ-014 err_o  output  IN_W  signed quantization error of that sample.
REQ-015 ovl_o  output  1  the sample in code_o was clamped.
REQ-016 ovl_cnt_o  output  CNT_W  saturating count of clamped samples.

Function
REQ-017 SHALL define STEP = 2^(IN_W-OUT_W), SH = IN_W-OUT_W, internal width ACC_W = IN_W+3, all arithmetic signed.
REQ-018 SHALL set in_ready_o = !out_valid_o || out_ready_i; a sample is accepted when in_valid_i && in_ready_o.
REQ-019 SHALL form v = x + F with F = 0 (mode 00/11), e1 (mode 01), 2*e1 - e2 (mode 10), mode_i sampled at acceptance.
REQ-020 SHALL compute q = (v + STEP/2) >>> SH (arithmetic, floor), clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; ovl = clamp occurred.
REQ-021 SHALL compute e = v - q_clamped*STEP, saturated to signed IN_W range.
REQ-022 SHALL, on acceptance, register code_o = q_clamped + 2^(OUT_W-1), err_o = e, ovl_o = ovl, set out_valid_o, and shift e2 <= e1, e1 <= e (latency 1 cycle).
REQ-023 SHALL clear out_valid_o when out_valid_o && out_ready_i and no new acceptance in the same cycle.
REQ-024 SHALL hold code_o/err_o/ovl_o and e1/e2 stable while out_valid_o && !out_ready_i.
REQ-025 SHALL increment ovl_cnt_o on each accepted clamped sample, saturating at 2^CNT_W-1.
REQ-026 SHALL, on clr_i, zero e1, e2, ovl_cnt_o; a sample accepted in the same cycle uses F = 0, its result is registered normally, and its error is discarded (e1/e2 remain 0); its overload counts from 0.
REQ-027 SHALL not alter out_valid_o or output data on clr_i.

Reset
REQ-028 SHALL, on rst_i, drive out_valid_o=0, code_o=0, err_o=0, ovl_o=0, ovl_cnt_o=0, e1=e2=0; in_ready_o=1 after reset.
REQ-029 SHALL discard any in-flight result on reset mid-stream; first post-reset sample uses F = 0.

Structure
REQ-030 SHALL place mode enum (MODE_PLAIN, MODE_EF1, MODE_EF2, MODE_RSVD) and ACC_W derivation in ns_quantizer_pkg.
REQ-031 SHALL isolate the combinational round/clamp/error path in sub-module ns_quant_core (inputs v; outputs q_clamped, e, ovl).

Verification (IN_W=16, OUT_W=3, STEP=8192)
REQ-032 Reset asserted mid-stream -> all outputs 0, in_ready_o=1, next sample x=4096 mode 01 -> code 5, err -4096.
REQ-033 Mode 00, x=0 -> code 4, err 0; x=12288 -> code 6, err -4096; x=-32768 -> code 0, err 0, ovl 0.
REQ-034 Mode 00, x=32767 -> code 7, err 8191, ovl 1, ovl_cnt_o +1; 2^CNT_W+2 overloads -> counter stays at max.
REQ-035 Mode 01, x=4096 constant -> codes 5,4,5,4..., errors -4096,0,-4096,0; mode 10 constant x=4096 -> mean code 4.5 over 8 samples.
REQ-036 out_ready_i=0 for 5 cycles with out_valid_o=1 -> in_ready_o=0, outputs and e1/e2 frozen; release -> sequence continues without loss or duplicate.
REQ-037 clr_i with simultaneous accepted sample, mode 01 -> that sample uses F=0, ovl_cnt_o=0 (or 1 if clamped), next sample uses F=0.
